// File: rtl/color_ramp.sv
// color_ramp: ramps three 8-bit PWM duty values toward loaded targets.
// Latency: duty follows lin directly; one extra cycle on duty/busy/done with COLOR_RAMP_GAMMA_EN.
// Backpressure: none; load is accepted in any cycle and retargets from the current values.
module color_ramp #(
  parameter int PRESCALE = 256,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] target_r,
  input  logic [7:0] target_g,
  input  logic [7:0] target_b,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  localparam logic [15:0]       TICK_LAST = 16'(PRESCALE - 1);
  localparam logic signed [8:0] STEP_S    = 9'(STEP);
  localparam logic [7:0]        STEP_U    = 8'(STEP);

  state_t     state_q, state_d;
  logic [7:0] lin_r_q, lin_g_q, lin_b_q;
  logic [7:0] lin_r_d, lin_g_d, lin_b_d;
  logic [7:0] tgt_r_q, tgt_g_q, tgt_b_q;
  logic [7:0] tgt_r_d, tgt_g_d, tgt_b_d;
  logic [15:0] tick_q, tick_d;
  logic       done_q, done_d;
  logic       step_w;
  logic [7:0] nxt_r, nxt_g, nxt_b;

  // Move one channel toward its target by at most STEP; the signed 9-bit
  // difference keeps the clamp exact at both ends of the 0..255 range.
  function automatic logic [7:0] step_toward(input logic [7:0] lin, input logic [7:0] tgt);
    logic signed [8:0] diff;
    logic [7:0]        res;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, lin});
    if (diff > STEP_S)       res = lin + STEP_U;
    else if (diff < -STEP_S) res = lin - STEP_U;
    else                     res = tgt;
    return res;
  endfunction

  assign step_w = (state_q == RAMP) && (tick_q == TICK_LAST);
  assign nxt_r  = step_toward(lin_r_q, tgt_r_q);
  assign nxt_g  = step_toward(lin_g_q, tgt_g_q);
  assign nxt_b  = step_toward(lin_b_q, tgt_b_q);

  // Next-state: load beats a coincident step; a finished step returns to IDLE with done.
  always_comb begin
    state_d = state_q;
    lin_r_d = lin_r_q;
    lin_g_d = lin_g_q;
    lin_b_d = lin_b_q;
    tgt_r_d = tgt_r_q;
    tgt_g_d = tgt_g_q;
    tgt_b_d = tgt_b_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    if (load) begin
      tgt_r_d = target_r;
      tgt_g_d = target_g;
      tgt_b_d = target_b;
      tick_d  = 16'd0;
      if (target_r == lin_r_q && target_g == lin_g_q && target_b == lin_b_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if (state_q == RAMP) begin
      if (step_w) begin
        lin_r_d = nxt_r;
        lin_g_d = nxt_g;
        lin_b_d = nxt_b;
        tick_d  = 16'd0;
        if (nxt_r == tgt_r_q && nxt_g == tgt_g_q && nxt_b == tgt_b_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        tick_d = tick_q + 16'd1;
      end
    end else begin
      tick_d = 16'd0;
    end
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lin_r_q <= 8'd0;
      lin_g_q <= 8'd0;
      lin_b_q <= 8'd0;
      tgt_r_q <= 8'd0;
      tgt_g_q <= 8'd0;
      tgt_b_q <= 8'd0;
      tick_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_r_q <= lin_r_d;
      lin_g_q <= lin_g_d;
      lin_b_q <= lin_b_d;
      tgt_r_q <= tgt_r_d;
      tgt_g_q <= tgt_g_d;
      tgt_b_q <= tgt_b_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

`ifdef COLOR_RAMP_GAMMA_EN
  logic [15:0] sq_r, sq_g, sq_b;
  logic [7:0]  duty_r_q, duty_g_q, duty_b_q;
  logic        busy_q, done_dly_q;

  assign sq_r = ({8'd0, lin_r_q} * {8'd0, lin_r_q}) + {8'd0, lin_r_q};
  assign sq_g = ({8'd0, lin_g_q} * {8'd0, lin_g_q}) + {8'd0, lin_g_q};
  assign sq_b = ({8'd0, lin_b_q} * {8'd0, lin_b_q}) + {8'd0, lin_b_q};

  // Gamma stage: register (x*x + x) >> 8 and delay busy/done to stay aligned with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_r_q   <= 8'd0;
      duty_g_q   <= 8'd0;
      duty_b_q   <= 8'd0;
      busy_q     <= 1'b0;
      done_dly_q <= 1'b0;
    end else begin
      duty_r_q   <= sq_r[15:8];
      duty_g_q   <= sq_g[15:8];
      duty_b_q   <= sq_b[15:8];
      busy_q     <= (state_q == RAMP);
      done_dly_q <= done_q;
    end
  end

  assign duty_r = duty_r_q;
  assign duty_g = duty_g_q;
  assign duty_b = duty_b_q;
  assign busy   = busy_q;
  assign done   = done_dly_q;
`else
  assign duty_r = lin_r_q;
  assign duty_g = lin_g_q;
  assign duty_b = lin_b_q;
  assign busy   = (state_q == RAMP);
  assign done   = done_q;
`endif

endmodule

// File: doc/color_ramp.md
COLOR_RAMP -- requirements
Module: color_ramp

Interface
REQ-001 Parameter PRESCALE, default 256, clk cycles per ramp step (legal 1..65535).
REQ-002 Parameter STEP, default 1, maximum duty change per channel per step (legal 1..255).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  single-cycle strobe; captures target_r/g/b.
REQ-006 target_r, target_g, target_b  input  8 each  requested duty per channel.
REQ-007 duty_r, duty_g, duty_b  output  8 each  registered duty values feeding the three downstream pwm stages.
REQ-008 busy  output  1  high while ramping toward the target.
REQ-009 done  output  1  one-cycle pulse when all channels reach the target.

Function
REQ-010 Two states, IDLE and RAMP; the state register, the three linear duty registers (lin_r/g/b), the three target registers and the tick counter are all registered.
REQ-011 load=1 in any state: capture targets, clear the tick counter, enter RAMP next cycle; busy=1 from that cycle.
REQ-012 load=1 with targets equal to the current lin values: no RAMP; done pulses the next cycle, busy stays 0.
REQ-013 In RAMP, the tick counter counts 0..PRESCALE-1 and wraps; a step occurs in the cycle it holds PRESCALE-1.
REQ-014 On a step, each channel moves toward its target by min(STEP, |target-lin|); no overshoot, no wrap past 0 or 255; the difference is computed at 9 bits, signed.
REQ-015 Channels step independently; a channel already at its target holds.
REQ-016 The first step after load occurs PRESCALE cycles after load is sampled.
REQ-017 When all three lin values equal their targets after a step: RAMP->IDLE, busy=0 and done=1 in the same cycle; done lasts exactly one cycle.
REQ-018 load during RAMP retargets from the current lin values; the abandoned ramp produces no done pulse.
REQ-019 load and a step in the same cycle: load wins; the step is discarded and the counter clears.
REQ-020 In IDLE, the tick counter holds at 0 and lin values hold.
REQ-021 Target inputs are ignored except in cycles with load=1.

Reset
REQ-022 reset=1 on a clk edge: state=IDLE, lin, targets, duty outputs and counter=0, busy=0, done=0.
REQ-023 reset has priority over load and over an in-progress ramp; a ramp interrupted by reset produces no done.
REQ-024 The first load is accepted in the first cycle after reset deasserts.

Configuration
REQ-025 Macro COLOR_RAMP_GAMMA_EN.
REQ-026 Defined: duty_x = (lin_x*lin_x + lin_x) >> 8, computed at 16 bits and registered; 0->0, 128->64, 255->255.
REQ-027 Defined: duty outputs lag lin by one cycle, and done/busy are delayed one cycle to stay aligned with the outputs.
REQ-028 Not defined: duty_x is lin_x directly, with no extra latency, no multiplier and no delay registers.

Verification (PRESCALE=4, STEP=1 unless noted; gamma off unless noted)
REQ-029 Reset, then load 10/0/255 from 0/0/0 -> busy=1; duty_r +1 every 4 cycles, duty_b +1 every 4 cycles; done after 255 steps with duty=10/0/255.
REQ-030 STEP=16, lin_r=250, load target_r=255 -> one step to 255, no overshoot; lin_r=5, target_r=0 -> 0, no underflow.
REQ-031 load 200 mid-ramp at lin_r=50 (target 100), then load 20 -> ramp reverses from 50, exactly one done pulse, at lin_r=20.
REQ-032 load with target equal to current -> done the next cycle, busy never high; load coincident with a step edge -> step discarded, next step 4 cycles later.
REQ-033 Assert reset mid-ramp -> all outputs 0 the next cycle, no done; load on the first post-reset cycle is accepted.
REQ-034 COLOR_RAMP_GAMMA_EN defined, ramp to 128 and to 255 -> duty_r=64 and 255, done one cycle after lin reaches the target.
